seg7_scan_rx: RTL and testbench
===============================

SEG7_SCAN_RX -- requirements
Module: seg7_scan_rx

Interface
REQ-001 Parameter STABLE_CYC, default 4, legal range 2..15: the number of consecutive clock edges a scan pattern must hold before it is accepted.
REQ-002 clk  input  1  Sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  Reset, asynchronous, active-high.
REQ-004 clr  input  1  Synchronous clear of the digit store and error count; active-high.
REQ-005 seg_n  input  7  Active-low segments; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-006 an_n  input  8  Active-low digit select; legal only when exactly one bit is low (bit i = digit i).
REQ-007 hex_out  output  32  Decoded nibbles; digit i occupies bits [4i+3:4i].
REQ-008 dig_valid  output  8  Bit i is high once digit i holds a legally decoded hex value.
REQ-009 dig_blank  output  8  Bit i is high when the last pattern accepted for digit i was all-off (7'b1111111).
REQ-010 upd_valid  output  1  One-cycle pulse marking an accepted pattern.
REQ-011 upd_idx  output  3  Digit index of the accepted pattern; meaningful while upd_valid is high.
REQ-012 upd_err  output  1  Qualifies upd_valid; high when the accepted pattern is not a legal glyph.
REQ-013 err_cnt  output  8  Saturating count of illegal glyphs accepted.

Function
REQ-014 seg_n and an_n SHALL be registered once into a sample stage (s_seg, s_an); all decisions SHALL use the sample stage.
REQ-015 Stability counter, 4 bits:
  - Cleared when the new sample differs from the held sample in any of the 15 bits.
  - Cleared when s_an is not one-hot-low.
  - Otherwise increments, saturating at STABLE_CYC-1.
REQ-016 Acceptance SHALL occur on the edge at which the counter first reaches STABLE_CYC-1 with s_an legal. The "accepted" flag then blocks re-acceptance until the sample changes. Timing: a pattern applied before edge 0 SHALL update outputs at edge STABLE_CYC, with upd_valid high for that one cycle.
REQ-017 Decode table (seg_n -> nibble):
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
REQ-018 On acceptance of a legal glyph for digit i:
  - Write the nibble into hex_out[4i+3:4i].
  - Set dig_valid[i]; clear dig_blank[i].
  - upd_err=0.
REQ-019 On acceptance of 1111111 for digit i:
  - Set dig_blank[i]; clear dig_valid[i].
  - Leave the nibble unchanged.
  - upd_err=0.
REQ-020 On acceptance of any other pattern:
  - Leave the nibble and dig_valid[i] unchanged; clear dig_blank[i].
  - upd_err=1.
  - err_cnt increments, saturating at 255.
REQ-021 an_n with zero or more than one low bit SHALL never produce acceptance and SHALL NOT count as an error.
REQ-022 clr SHALL zero hex_out, dig_valid, dig_blank and err_cnt on the next edge.
REQ-023 clr SHALL suppress any acceptance on that same edge (clr wins).
REQ-024 clr SHALL NOT reset the sample stage or the stability counter.
REQ-025 upd_idx SHALL equal the index of the single low bit of s_an at acceptance.
REQ-026 Back-to-back patterns SHALL each be accepted independently; the minimum spacing between pulses is STABLE_CYC edges.

Reset
REQ-027 rst high SHALL asynchronously zero the following:
  - All outputs.
  - The stability counter and the accepted flag.
REQ-028 rst high SHALL asynchronously set s_seg=7'h7F and s_an=8'hFF.
REQ-029 Reset asserted mid-count SHALL discard the partial count; acceptance requires a full STABLE_CYC run after release.

Structure
REQ-030 Package seg7_pkg SHALL hold the 16 glyph constants, the blank constant, and the default STABLE_CYC.
REQ-031 A combinational sub-module seg7_decode (seg_n in; nibble, is_blank, is_illegal out) SHALL implement REQ-017; seg7_scan_rx SHALL instantiate it once.

Verification
REQ-032 STABLE_CYC=4, an_n=8'hFE, seg_n=0000110 held 6 cycles -> single upd_valid pulse at edge 4, upd_idx=0, hex_out[3:0]=3, dig_valid=8'h01.
REQ-033 Scan digits 0..7 with glyphs 0,1,...,7, each held 5 cycles -> 8 pulses; hex_out=32'h76543210, dig_valid=8'hFF.
REQ-034 an_n=8'hFC (two digits) held 10 cycles -> no pulse, err_cnt=0; then an_n=8'hFB with a 3-cycle glitch -> no pulse.
REQ-035 Digit 2 holds 5; then seg_n=1111111 -> dig_blank[2]=1, dig_valid[2]=0, nibble still 5; then seg_n=1010101 -> upd_err=1, err_cnt=1.
REQ-036 Illegal glyph accepted 300 times (alternating digits) -> err_cnt=255.
REQ-036a clr pulsed on the acceptance edge -> no pulse, all outputs 0.
REQ-036b rst asserted at count 2 -> outputs 0 immediately; acceptance occurs STABLE_CYC edges after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Glyph table, blank pattern and digit-select helpers shared by the scan receiver.
// Pure constants and functions; no state.
package seg7_pkg;

   localparam int STABLE_CYC_DEF = 4;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low a..g patterns, indexed by the hex value they display
   localparam logic [6:0] GLYPH [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   function automatic logic an_legal(input logic [7:0] an);
      return $onehot(~an);
   endfunction

   function automatic logic [2:0] an_index(input logic [7:0] an);
      logic [2:0] i;
      i = '0;
      for (int k = 0; k < 8; k++)
         if (!an[k]) i = 3'(k);
      return i;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Segment pattern to hex nibble decoder, purely combinational (zero latency).
// No flow control: output follows input.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] nibble,
   output logic       is_blank,
   output logic       is_illegal
);

   always_comb begin
      nibble     = '0;
      is_blank   = (seg_n == SEG_BLANK);
      is_illegal = !is_blank;
      for (int k = 0; k < 16; k++) begin
         if (seg_n == GLYPH[k]) begin
            nibble     = 4'(k);
            is_illegal = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_rx.sv
// Recovers hex digits from a multiplexed 7-segment scan; a pattern is accepted after STABLE_CYC stable samples.
// Outputs update STABLE_CYC edges after a pattern appears; no backpressure, upd_valid is a one-cycle pulse.
module seg7_scan_rx
   import seg7_pkg::*;
#(
   parameter int STABLE_CYC = STABLE_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic [6:0]  seg_n,
   input  logic [7:0]  an_n,
   output logic [31:0] hex_out,
   output logic [7:0]  dig_valid,
   output logic [7:0]  dig_blank,
   output logic        upd_valid,
   output logic [2:0]  upd_idx,
   output logic        upd_err,
   output logic [7:0]  err_cnt
);

   localparam logic [3:0] CNT_MAX = 4'(STABLE_CYC - 1);

   logic [6:0] s_seg, h_seg;
   logic [7:0] s_an, h_an;
   logic [3:0] cnt, cnt_nxt;
   logic       acc, acc_nxt;
   logic       same, legal, accept, commit;
   logic [2:0] idx;
   logic [3:0] nibble;
   logic       is_blank, is_illegal;

   seg7_decode u_dec (
      .seg_n      (s_seg),
      .nibble     (nibble),
      .is_blank   (is_blank),
      .is_illegal (is_illegal)
   );

   // h_* keeps the previous sample so stability is judged entirely within the sample stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_seg <= SEG_BLANK;
         s_an  <= 8'hFF;
         h_seg <= SEG_BLANK;
         h_an  <= 8'hFF;
      end else begin
         s_seg <= seg_n;
         s_an  <= an_n;
         h_seg <= s_seg;
         h_an  <= s_an;
      end
   end

   always_comb begin
      same    = (s_seg == h_seg) && (s_an == h_an);
      legal   = an_legal(s_an);
      idx     = an_index(s_an);
      cnt_nxt = '0;
      acc_nxt = 1'b0;
      accept  = 1'b0;
      if (same && legal) begin
         cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
         accept  = (cnt_nxt == CNT_MAX) && !acc;
         acc_nxt = acc || accept;
      end
      commit = accept && !clr;
   end

   // A pattern swallowed by clr still marks itself accepted so it is not taken on the next edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         acc <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         acc <= acc_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hex_out   <= '0;
         dig_valid <= '0;
         dig_blank <= '0;
         err_cnt   <= '0;
         upd_valid <= 1'b0;
         upd_idx   <= '0;
         upd_err   <= 1'b0;
      end else begin
         upd_valid <= commit;
         if (clr) begin
            hex_out   <= '0;
            dig_valid <= '0;
            dig_blank <= '0;
            err_cnt   <= '0;
         end else if (commit) begin
            upd_idx <= idx;
            upd_err <= is_illegal;
            if (is_blank) begin
               dig_blank[idx] <= 1'b1;
               dig_valid[idx] <= 1'b0;
            end else if (is_illegal) begin
               dig_blank[idx] <= 1'b0;
               if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
               hex_out[{idx, 2'b00} +: 4] <= nibble;
               dig_valid[idx]             <= 1'b1;
               dig_blank[idx]             <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Bench for seg7_scan_rx: directed scenarios plus random scans against a run-length reference model.
// Expected pulses are queued at stimulus time and popped by an independent monitor.
module tb_seg7_scan_rx;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst, clr;
   logic [6:0]  seg_n;
   logic [7:0]  an_n;
   logic [31:0] hex_out;
   logic [7:0]  dig_valid, dig_blank, err_cnt;
   logic        upd_valid, upd_err;
   logic [2:0]  upd_idx;

   seg7_scan_rx #(.STABLE_CYC(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .seg_n     (seg_n),
      .an_n      (an_n),
      .hex_out   (hex_out),
      .dig_valid (dig_valid),
      .dig_blank (dig_blank),
      .upd_valid (upd_valid),
      .upd_idx   (upd_idx),
      .upd_err   (upd_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [2:0]  idx;
      logic        err;
      logic [31:0] hex;
      logic [7:0]  vld;
      logic [7:0]  blk;
      logic [7:0]  ec;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   armed  = 1'b0;

   logic [6:0] glyph [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   // Reference model: digit store plus run length of identical consecutive input samples
   logic [3:0]  m_hex [8];
   logic [7:0]  m_vld, m_blk;
   int          m_ec;
   logic [14:0] prev;
   int          run;
   bit          pend;
   logic [6:0]  p_seg;
   logic [7:0]  p_an;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] m_hexw();
      logic [31:0] w;
      for (int i = 0; i < 8; i++) w[4*i +: 4] = m_hex[i];
      return w;
   endfunction

   function automatic bit one_low(input logic [7:0] an);
      int z = 0;
      for (int i = 0; i < 8; i++) if (an[i] == 1'b0) z++;
      return z == 1;
   endfunction

   task automatic m_zero();
      for (int i = 0; i < 8; i++) m_hex[i] = 4'h0;
      m_vld = '0;
      m_blk = '0;
      m_ec  = 0;
   endtask

   task automatic m_accept(input logic [6:0] sg, input logic [7:0] an, input int e);
      exp_t x;
      int   idx = 0;
      int   k   = -1;
      for (int i = 0; i < 8; i++) if (an[i] == 1'b0) idx = i;
      for (int g = 0; g < 16; g++) if (glyph[g] == sg) k = g;
      if (k >= 0) begin
         m_hex[idx] = 4'(k);
         m_vld[idx] = 1'b1;
         m_blk[idx] = 1'b0;
         x.err      = 1'b0;
      end else if (sg == 7'h7F) begin
         m_blk[idx] = 1'b1;
         m_vld[idx] = 1'b0;
         x.err      = 1'b0;
      end else begin
         m_blk[idx] = 1'b0;
         x.err      = 1'b1;
         if (m_ec < 255) m_ec++;
      end
      x.cyc = e;
      x.idx = 3'(idx);
      x.hex = m_hexw();
      x.vld = m_vld;
      x.blk = m_blk;
      x.ec  = 8'(m_ec);
      sbq.push_back(x);
   endtask

   // Called at a falling edge: drives one cycle of inputs and advances the model past the next rising edge
   task automatic step(input logic [6:0] sg, input logic [7:0] an, input logic c);
      int e;
      seg_n = sg;
      an_n  = an;
      clr   = c;
      e     = cyc + 1;
      if (pend && !c) m_accept(p_seg, p_an, e);
      if (c) m_zero();
      pend = 1'b0;
      if ({sg, an} == prev) begin
         if (run <= S) run++;
      end else begin
         run = 1;
      end
      prev = {sg, an};
      if (run == S && one_low(an)) begin
         pend  = 1'b1;
         p_seg = sg;
         p_an  = an;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic hold(input logic [6:0] sg, input logic [7:0] an, input int n);
      for (int i = 0; i < n; i++) step(sg, an, 1'b0);
   endtask

   task automatic do_reset();
      #1 rst = 1'b1;
      #1;
      chk("rst_hex", hex_out, 32'h0);
      chk("rst_valid", 32'(dig_valid), 32'h0);
      chk("rst_blank", 32'(dig_blank), 32'h0);
      chk("rst_errcnt", 32'(err_cnt), 32'h0);
      chk("rst_upd", 32'({upd_valid, upd_err, upd_idx}), 32'h0);
      m_zero();
      run  = 0;
      pend = 1'b0;
      prev = {7'h7F, 8'hFF};
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_state(input string nm);
      chk({nm, "_hex"}, hex_out, m_hexw());
      chk({nm, "_valid"}, 32'(dig_valid), 32'(m_vld));
      chk({nm, "_blank"}, 32'(dig_blank), 32'(m_blk));
      chk({nm, "_errcnt"}, 32'(err_cnt), 32'(m_ec));
   endtask

   always @(negedge clk) begin
      if (armed && upd_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse actual=pulse idx=%0d required=no pulse (cycle %0d)", upd_idx, cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
            chk("pulse_idx", 32'(upd_idx), 32'(mon_e.idx));
            chk("pulse_err", 32'(upd_err), 32'(mon_e.err));
            chk("pulse_hex", hex_out, mon_e.hex);
            chk("pulse_valid", 32'(dig_valid), 32'(mon_e.vld));
            chk("pulse_blank", 32'(dig_blank), 32'(mon_e.blk));
            chk("pulse_errcnt", 32'(err_cnt), 32'(mon_e.ec));
         end
      end
   end

   initial begin
      logic [6:0] sg;
      logic [7:0] an;
      int         r;
      rst   = 1'b0;
      clr   = 1'b0;
      seg_n = 7'h7F;
      an_n  = 8'hFF;
      @(negedge clk);
      do_reset();
      armed = 1'b1;

      // Single glyph on digit 0
      hold(glyph[3], 8'hFE, 6);
      chk("g3_nibble", 32'(hex_out[3:0]), 32'h3);
      chk("g3_valid", 32'(dig_valid), 32'h01);
      chk_state("g3");

      // Full scan of glyphs 0..7
      for (int d = 0; d < 8; d++) hold(glyph[d], ~(8'(1) << d), 5);
      step(7'h7F, 8'hFF, 1'b0);
      chk("scan_hex", hex_out, 32'h76543210);
      chk("scan_valid", 32'(dig_valid), 32'hFF);
      chk_state("scan");

      // Two digits selected, then a short glitch on a legal digit
      hold(glyph[9], 8'hFC, 10);
      chk("two_low_errcnt", 32'(err_cnt), 32'h0);
      hold(glyph[5], 8'hFB, 3);
      hold(glyph[5], 8'hFC, 4);
      chk_state("glitch");

      // Digit 2: value, then blank, then an illegal pattern
      hold(glyph[5], 8'hFB, 5);
      hold(7'h7F, 8'hFB, 5);
      chk("blank_bit", 32'(dig_blank[2]), 32'h1);
      chk("blank_valid", 32'(dig_valid[2]), 32'h0);
      chk("blank_nibble", 32'(hex_out[11:8]), 32'h5);
      hold(7'b1010101, 8'hFB, 5);
      chk("illegal_errcnt", 32'(err_cnt), 32'h1);
      chk("illegal_blank", 32'(dig_blank[2]), 32'h0);
      chk_state("illegal");

      // clr landing on the acceptance edge
      hold(glyph[10], 8'h7F, 4);
      step(glyph[10], 8'h7F, 1'b1);
      hold(glyph[10], 8'h7F, 3);
      chk("clr_upd", 32'(upd_valid), 32'h0);
      chk("clr_hex", hex_out, 32'h0);
      chk("clr_flags", 32'({dig_valid, dig_blank, err_cnt}), 32'h0);
      chk_state("clr");

      // Reset in the middle of a count
      hold(glyph[9], 8'hDF, 5);
      hold(glyph[1], 8'hFE, 4);
      do_reset();
      hold(glyph[1], 8'hFE, S);
      chk("rstcnt_early", 32'(upd_valid), 32'h0);
      step(glyph[1], 8'hFE, 1'b0);
      chk("rstcnt_pulse", 32'(upd_valid), 32'h1);
      hold(glyph[1], 8'hFE, 2);
      chk_state("rstcnt");

      // Randomized scan traffic with occasional clears
      for (int p = 0; p < 150; p++) begin
         r = $urandom_range(0, 9);
         if (r < 7) an = ~(8'(1) << $urandom_range(0, 7));
         else       an = 8'($urandom);
         r = $urandom_range(0, 9);
         if (r < 5)      sg = glyph[$urandom_range(0, 15)];
         else if (r < 7) sg = 7'h7F;
         else            sg = 7'($urandom);
         r = $urandom_range(1, 6);
         for (int i = 0; i < r; i++) step(sg, an, $urandom_range(0, 24) == 0);
      end
      hold(7'h7F, 8'hFF, 2);
      chk_state("random");

      // Error counter saturation
      for (int i = 0; i < 300; i++) hold(7'b1010101, (i % 2 == 0) ? 8'hFD : 8'hFE, S);
      hold(7'h7F, 8'hFF, 2);
      chk("sat_errcnt", 32'(err_cnt), 32'hFF);
      chk_state("sat");

      hold(7'h7F, 8'hFF, 3);
      chk("sb_drain", 32'(sbq.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
